seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8: number of scanned digit positions (2..16).
REQ-002 SHALL have parameter STABLE_CNT, default 3: consecutive identical samples required to commit (1..15).
REQ-003 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port sample_en  in  1  qualifies seg_in/dig_sel sampling on the current edge.
REQ-006 SHALL have port dig_sel  in  NUM_DIGITS  one-hot digit select of the observed scanned display.
REQ-007 SHALL have port seg_in  in  7  segment bits {g,f,e,d,c,b,a}, active-high.
REQ-008 SHALL have port err_clr  in  1  clears illegal_err.
REQ-009 SHALL have port digits_bcd  out  4*NUM_DIGITS  committed code per digit; digit i at bits [4i+3:4i].
REQ-010 SHALL have port frame_done  out  1  one-cycle pulse when every digit has committed since the last pulse.
REQ-011 SHALL have port illegal_err  out  1  sticky flag: a stable pattern was not a legal glyph.
REQ-012 SHALL have port err_digit  out  clog2(NUM_DIGITS)  index of the digit that last set illegal_err.

Function
REQ-013 Decode SHALL map patterns 0111111,0000110,1011011,1001111,1100110,1101101,1111101,0000111,1111111,1101111 to 0..9, 0000000 to 4'hF (blank); all others illegal.
REQ-014 A sample SHALL be taken only on edges with sample_en=1; dig_sel not exactly one-hot SHALL discard the sample and clear the run counter.
REQ-015 Candidate (digit index, pattern) and run counter SHALL be held; a sample equal to the candidate increments the counter (saturating at STABLE_CNT), any other sample reloads the candidate with counter=1.
REQ-016 Commit SHALL occur on the edge where the counter reaches STABLE_CNT; digits_bcd updates on that same edge (latency 0 cycles after the qualifying sample edge).
REQ-017 Only one commit SHALL occur per run; further identical samples cause no commit until the candidate changes.
REQ-018 An illegal pattern at commit SHALL leave the digit unchanged, set illegal_err, load err_digit, and still count as refreshed.
REQ-019 A per-digit refresh mask SHALL set on commit; when all bits would be set, frame_done pulses 1 cycle and the mask clears on that edge (the committing digit is not carried over).
REQ-020 err_clr and a new illegal commit on the same edge: set SHALL win.
REQ-021 STABLE_CNT=1 SHALL commit on every valid sample whose candidate differs from the previous one.
REQ-022 sample_en=0 SHALL hold all state; gaps do not break a run.

Reset
REQ-023 rst=1 SHALL asynchronously set digits_bcd to all 4'hF, frame_done=0, illegal_err=0, err_digit=0, refresh mask=0, counter=0, candidate invalid.
REQ-024 Reset mid-run SHALL discard the run; the first post-reset sample starts counter at 1.

Configuration
REQ-025 Macro SEG_DP_EN SHALL, when defined, add port dp_in (in, 1) and dp_out (out, NUM_DIGITS): dp is part of the candidate comparison and dp_out[i] commits with digit i (reset 0).
REQ-026 Without SEG_DP_EN, no dp ports exist and comparison uses seg_in only.

Structure
REQ-027 Package seg_pkg SHALL hold the ten glyph constants, SEG_BLANK, BLANK_CODE (4'hF) and the segment-bit order.
REQ-028 Combinational sub-module seg_to_bcd (pattern -> code + illegal flag) SHALL be instantiated once on the candidate pattern.

Verification
REQ-029 STABLE_CNT=3, dig_sel=8'h01, seg_in=1011011 for 3 sample edges -> digits_bcd[3:0]=2 on 3rd edge; 4th sample no further commit.
REQ-030 Alternate seg_in 1001111/1100110 each edge on digit 0 -> no commit, digits_bcd stays 4'hF.
REQ-031 Scan digits 0..7 with digit i showing i, 3 samples each -> frame_done single pulse on digit 7 commit; digits_bcd=32'h76543210.
REQ-032 Stable 1110001 on digit 5 -> illegal_err=1, err_digit=5, digit 5 unchanged; err_clr same edge as next illegal commit -> illegal_err stays 1.
REQ-033 dig_sel=8'h03 between identical samples -> run restarts, commit needs 3 fresh samples.
REQ-034 rst asserted after 2 of 3 samples -> outputs reset immediately; post-reset commit needs 3 samples.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared glyph table and segment-bit ordering for the scanned 7-segment decoder.
// Bit order everywhere is {g,f,e,d,c,b,a}, active-high.
package seg_pkg;

    typedef struct packed {
        logic g;
        logic f;
        logic e;
        logic d;
        logic c;
        logic b;
        logic a;
    } seg_t;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [3:0] BLANK_CODE = 4'hF;

endpackage

// File: rtl/seg_to_bcd.sv
// Combinational glyph decoder: segment pattern to BCD code, blank maps to BLANK_CODE.
// Anything that is not a digit glyph or blank raises illegal.
module seg_to_bcd
    import seg_pkg::*;
(
    input  seg_t       pattern,
    output logic [3:0] code,
    output logic       illegal
);

    always_comb begin
        code    = BLANK_CODE;
        illegal = 1'b0;
        case (pattern)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = BLANK_CODE;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Debounces a sniffed multiplexed 7-segment display into per-digit BCD; a digit commits on the
// same edge its run of identical samples reaches STABLE_CNT. Optional SEG_DP_EN adds decimal points.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int STABLE_CNT = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_en,
    input  logic [NUM_DIGITS-1:0]         dig_sel,
    input  logic [6:0]                    seg_in,
    input  logic                          err_clr,
`ifdef SEG_DP_EN
    input  logic                          dp_in,
    output logic [NUM_DIGITS-1:0]         dp_out,
`endif
    output logic [4*NUM_DIGITS-1:0]       digits_bcd,
    output logic                          frame_done,
    output logic                          illegal_err,
    output logic [$clog2(NUM_DIGITS)-1:0] err_digit
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
`ifdef SEG_DP_EN
    localparam int PAT_W = 8;
`else
    localparam int PAT_W = 7;
`endif
    localparam logic [3:0] STABLE = 4'(STABLE_CNT);

    logic [PAT_W-1:0]             sample_pat, cand_pat, cand_pat_nxt;
    logic [IDX_W-1:0]             sel_idx, cand_idx, cand_idx_nxt;
    logic                         cand_vld, cand_vld_nxt;
    logic                         sel_ok, commit, frame_hit;
    logic [3:0]                   run_cnt, cnt_nxt;
    logic [3:0]                   dec_code;
    logic                         dec_illegal;
    logic [NUM_DIGITS-1:0]        refresh, refresh_set;
    logic [NUM_DIGITS-1:0][3:0]   digits_q;

`ifdef SEG_DP_EN
    assign sample_pat = {dp_in, seg_in};
`else
    assign sample_pat = seg_in;
`endif

    always_comb begin
        sel_ok  = ($countones(dig_sel) == 1);
        sel_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_sel[i]) sel_idx = IDX_W'(i);
        end
    end

    // Run tracking; a commit fires only on the transition into STABLE, never while saturated.
    always_comb begin
        cand_vld_nxt = cand_vld;
        cand_idx_nxt = cand_idx;
        cand_pat_nxt = cand_pat;
        cnt_nxt      = run_cnt;
        commit       = 1'b0;
        if (sample_en) begin
            if (!sel_ok) begin
                cnt_nxt = '0;
            end else if (cand_vld && cand_idx == sel_idx && cand_pat == sample_pat) begin
                if (run_cnt != STABLE) begin
                    cnt_nxt = run_cnt + 4'd1;
                    commit  = (cnt_nxt == STABLE);
                end
            end else begin
                cand_vld_nxt = 1'b1;
                cand_idx_nxt = sel_idx;
                cand_pat_nxt = sample_pat;
                cnt_nxt      = 4'd1;
                commit       = (STABLE == 4'd1);
            end
        end
    end

    seg_to_bcd u_dec (
        .pattern (cand_pat_nxt[6:0]),
        .code    (dec_code),
        .illegal (dec_illegal)
    );

    assign refresh_set = refresh | (commit ? dig_sel : '0);
    assign frame_hit   = commit && (&refresh_set);
    assign digits_bcd  = digits_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_vld    <= 1'b0;
            cand_idx    <= '0;
            cand_pat    <= '0;
            run_cnt     <= '0;
            refresh     <= '0;
            frame_done  <= 1'b0;
            illegal_err <= 1'b0;
            err_digit   <= '0;
            digits_q    <= {NUM_DIGITS{BLANK_CODE}};
        end else begin
            cand_vld   <= cand_vld_nxt;
            cand_idx   <= cand_idx_nxt;
            cand_pat   <= cand_pat_nxt;
            run_cnt    <= cnt_nxt;
            frame_done <= frame_hit;
            refresh    <= frame_hit ? '0 : refresh_set;
            if (commit && !dec_illegal) digits_q[cand_idx_nxt] <= dec_code;
            // A fresh illegal commit outranks a simultaneous clear.
            if (commit && dec_illegal) begin
                illegal_err <= 1'b1;
                err_digit   <= cand_idx_nxt;
            end else if (err_clr) begin
                illegal_err <= 1'b0;
            end
        end
    end

`ifdef SEG_DP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_out <= '0;
        end else if (commit && !dec_illegal) begin
            dp_out[cand_idx_nxt] <= cand_pat_nxt[7];
        end
    end
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomised and directed bench for seg_scan_decoder with a run-length reference model and
// a per-cycle expected-state scoreboard.
module tb_seg_scan_decoder;

    localparam int N  = 8;
    localparam int SC = 3;

    logic        clk = 1'b0;
    logic        rst, sample_en, err_clr;
    logic [7:0]  dig_sel;
    logic [6:0]  seg_in;
    logic [31:0] digits_bcd;
    logic        frame_done, illegal_err;
    logic [2:0]  err_digit;

    always #5 clk = ~clk;

    seg_scan_decoder #(.NUM_DIGITS(N), .STABLE_CNT(SC)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_en   (sample_en),
        .dig_sel     (dig_sel),
        .seg_in      (seg_in),
        .err_clr     (err_clr),
        .digits_bcd  (digits_bcd),
        .frame_done  (frame_done),
        .illegal_err (illegal_err),
        .err_digit   (err_digit)
    );

    typedef struct {
        logic [31:0] digits;
        logic        frame;
        logic        ill;
        logic [2:0]  errd;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [6:0] glyphs [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    // Reference model state: plain run length, no saturation.
    int         m_digit [N];
    bit         m_mask  [N];
    bit         m_ill, m_frame, m_cvld;
    int         m_errd, m_cidx, m_run;
    logic [6:0] m_cpat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int decode(input logic [6:0] p);
        if (p == 7'b0) return 15;
        for (int k = 0; k < 10; k++) if (glyphs[k] == p) return k;
        return -1;
    endfunction

    function automatic void model_step(input bit en, input logic [7:0] sel, input logic [6:0] seg,
                                       input bit clr, input bit r);
        bit set_err = 0;
        m_frame = 0;
        if (r) begin
            for (int k = 0; k < N; k++) begin m_digit[k] = 15; m_mask[k] = 0; end
            m_ill = 0; m_errd = 0; m_cvld = 0; m_run = 0; m_cidx = 0; m_cpat = '0;
            return;
        end
        if (en) begin
            if ($countones(sel) != 1) begin
                m_run = 0;
            end else begin
                int idx = 0;
                for (int k = 0; k < N; k++) if (sel[k]) idx = k;
                if (m_cvld && idx == m_cidx && seg == m_cpat) m_run++;
                else begin m_cvld = 1; m_cidx = idx; m_cpat = seg; m_run = 1; end
                if (m_run == SC) begin
                    int code = decode(seg);
                    bit all = 1;
                    if (code < 0) begin set_err = 1; m_ill = 1; m_errd = idx; end
                    else m_digit[idx] = code;
                    m_mask[idx] = 1;
                    for (int k = 0; k < N; k++) all &= m_mask[k];
                    if (all) begin
                        m_frame = 1;
                        for (int k = 0; k < N; k++) m_mask[k] = 0;
                    end
                end
            end
        end
        if (clr && !set_err) m_ill = 0;
    endfunction

    task automatic cyc(input bit en, input logic [7:0] sel, input logic [6:0] seg,
                       input bit clr, input bit r);
        exp_t e;
        @(negedge clk);
        sample_en = en; dig_sel = sel; seg_in = seg; err_clr = clr; rst = r;
        model_step(en, sel, seg, clr, r);
        e.digits = '0;
        for (int k = 0; k < N; k++) e.digits |= (32'(m_digit[k]) << (4 * k));
        e.frame = m_frame;
        e.ill   = m_ill;
        e.errd  = 3'(m_errd);
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("digits_bcd",  digits_bcd,          mon_e.digits);
            check("frame_done",  32'(frame_done),     32'(mon_e.frame));
            check("illegal_err", 32'(illegal_err),    32'(mon_e.ill));
            check("err_digit",   32'(err_digit),      32'(mon_e.errd));
        end
    end

    initial begin
        logic [7:0] r_sel;
        logic [6:0] r_seg;
        rst = 1'b1; sample_en = 1'b0; dig_sel = '0; seg_in = '0; err_clr = 1'b0;
        repeat (3) cyc(0, 8'h00, 7'h00, 0, 1);

        // Alternating patterns never settle.
        for (int k = 0; k < 6; k++) cyc(1, 8'h01, (k % 2 != 0) ? 7'b1100110 : 7'b1001111, 0, 0);
        cyc(0, 8'h00, 7'h00, 0, 0);
        check("alt_no_commit", digits_bcd, 32'hFFFF_FFFF);

        // Three samples commit '2'; the fourth changes nothing.
        repeat (4) cyc(1, 8'h01, 7'b1011011, 0, 0);

        // Full scan 0..7; frame pulses on the digit-7 commit.
        for (int i = 0; i < 8; i++) repeat (3) cyc(1, 8'(1 << i), glyphs[i], 0, 0);
        cyc(0, 8'h00, 7'h00, 0, 0);
        check("scan_digits", digits_bcd, 32'h7654_3210);
        check("scan_frame",  32'(frame_done), 32'd1);

        // Illegal glyph on digit 5, then illegal commit on digit 6 with a simultaneous clear.
        repeat (3) cyc(1, 8'h20, 7'b1110001, 0, 0);
        cyc(0, 8'h00, 7'h00, 0, 0);
        check("ill_set",    32'(illegal_err), 32'd1);
        check("ill_digit5", 32'(err_digit), 32'd5);
        check("ill_keep5",  32'(digits_bcd[23:20]), 32'd5);
        repeat (2) cyc(1, 8'h40, 7'b1110001, 0, 0);
        cyc(1, 8'h40, 7'b1110001, 1, 0);
        cyc(0, 8'h00, 7'h00, 0, 0);
        check("ill_set_wins", 32'(illegal_err), 32'd1);
        check("ill_digit6",   32'(err_digit), 32'd6);
        cyc(0, 8'h00, 7'h00, 1, 0);
        cyc(0, 8'h00, 7'h00, 0, 0);
        check("ill_cleared", 32'(illegal_err), 32'd0);

        // Two-hot select breaks the run.
        repeat (2) cyc(1, 8'h02, glyphs[9], 0, 0);
        cyc(1, 8'h03, glyphs[9], 0, 0);
        repeat (2) cyc(1, 8'h02, glyphs[9], 0, 0);
        cyc(0, 8'h00, 7'h00, 0, 0);
        check("restart_hold", 32'(digits_bcd[7:4]), 32'd1);
        cyc(1, 8'h02, glyphs[9], 0, 0);
        cyc(0, 8'h00, 7'h00, 0, 0);
        check("restart_commit", 32'(digits_bcd[7:4]), 32'd9);

        // Reset mid-run takes effect before the next clock edge.
        repeat (2) cyc(1, 8'h04, glyphs[8], 0, 0);
        cyc(0, 8'h00, 7'h00, 0, 1);
        #1;
        check("async_rst_digits", digits_bcd, 32'hFFFF_FFFF);
        check("async_rst_frame",  32'(frame_done), 32'd0);
        check("async_rst_errd",   32'(err_digit), 32'd0);
        cyc(0, 8'h00, 7'h00, 0, 1);
        repeat (2) cyc(1, 8'h04, glyphs[8], 0, 0);
        cyc(0, 8'h00, 7'h00, 0, 0);
        check("post_rst_hold", 32'(digits_bcd[11:8]), 32'hF);
        cyc(1, 8'h04, glyphs[8], 0, 0);
        cyc(0, 8'h00, 7'h00, 0, 0);
        check("post_rst_commit", 32'(digits_bcd[11:8]), 32'd8);

        // Random scan traffic with held patterns so runs form.
        r_sel = 8'h01; r_seg = glyphs[0];
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                int s = $urandom_range(0, 13);
                if (s < 10)       r_seg = glyphs[s];
                else if (s == 10) r_seg = 7'b0000000;
                else if (s == 11) r_seg = 7'b1110001;
                else              r_seg = 7'($urandom);
                if ($urandom_range(0, 9) == 0) r_sel = 8'($urandom);
                else                           r_sel = 8'(1 << $urandom_range(0, 7));
            end
            cyc($urandom_range(0, 3) != 0, r_sel, r_seg, $urandom_range(0, 15) == 0,
                $urandom_range(0, 299) == 0);
        end

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
